// File: rtl/axi4_pkg.sv
// Shared AXI4 types and helpers for the axi4_slave_mem slice.
package axi4_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  // Bytes moved per beat for an AxSIZE encoding.
  function automatic logic [7:0] size_bytes(input logic [2:0] size);
    return 8'd1 << size;
  endfunction

endpackage

// File: rtl/axi4_slave_mem_if.sv
// AXI4 five-channel bundle (no AXI3 WID) with master/slave modports.
interface axi4_slave_mem_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 4
);
  logic [ID_W-1:0]     AWID;
  logic [ADDR_W-1:0]   AWADDR;
  logic [7:0]          AWLEN;
  logic [2:0]          AWSIZE;
  logic [1:0]          AWBURST;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;
  logic [ID_W-1:0]     BID;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ID_W-1:0]     ARID;
  logic [ADDR_W-1:0]   ARADDR;
  logic [7:0]          ARLEN;
  logic [2:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic                ARVALID;
  logic                ARREADY;
  logic [ID_W-1:0]     RID;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );
endinterface

// File: rtl/axi4_burst_addr.sv
// Combinational beat-address stepper: next address for FIXED/INCR/WRAP and
// an error flag for the current beat (size, burst type, wrap length, range).
module axi4_burst_addr
  import axi4_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              err
);
  localparam int unsigned LSB = $clog2(DATA_W / 8);

  logic [ADDR_W-1:0] bytes;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] base;

  // Next beat address and per-beat error classification.
  always_comb begin
    bytes     = ADDR_W'(size_bytes(size));
    span      = (ADDR_W'(len) + ADDR_W'(1)) << size;
    base      = addr & ~(span - ADDR_W'(1));
    next_addr = addr;
    case (burst)
      FIXED:   next_addr = addr;
      INCR:    next_addr = addr + bytes;
      WRAP:    next_addr = base + ((addr + bytes - base) & (span - ADDR_W'(1)));
      default: next_addr = addr;
    endcase
    err = (size > 3'(LSB))
       || (burst == 2'b11)
       || ((burst == WRAP) && !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)))
       || ((addr >> LSB) >= ADDR_W'(MEM_WORDS));
  end
endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory with independent write and read burst engines.
// Optional: define AXI4_SLV_WLAST_CHK_EN to flag WLAST/beat-count mismatch
// as SLVERR on the write response.
module axi4_slave_mem
  import axi4_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned MEM_WORDS = 1024
) (
  input logic              ACLK,
  input logic              ARESET,
  axi4_slave_mem_if.slave  s
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  wr_state_e w_state_q, w_state_d;
  logic [ID_W-1:0] w_id_q, w_id_d, bid_q, bid_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d, w_next;
  logic [7:0] w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic [2:0] w_size_q, w_size_d;
  logic [1:0] w_burst_q, w_burst_d, bresp_q, bresp_d;
  logic w_err_q, w_err_d, awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic w_beat_err, wlast_err, w_err_any, mem_we;

  rd_state_e r_state_q, r_state_d;
  logic [ID_W-1:0] r_id_q, r_id_d, rid_q, rid_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d, r_next, r_sel_addr;
  logic [7:0] r_len_q, r_len_d, r_sel_len;
  logic [8:0] r_beat_q, r_beat_d;
  logic [2:0] r_size_q, r_size_d, r_sel_size;
  logic [1:0] r_burst_q, r_burst_d, r_sel_burst, rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, rd_beat_data;
  logic arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d, r_err;

  axi4_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS)) u_wr_addr (
    .addr(w_addr_q), .len(w_len_q), .size(w_size_q), .burst(w_burst_q),
    .next_addr(w_next), .err(w_beat_err)
  );

  axi4_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS)) u_rd_addr (
    .addr(r_sel_addr), .len(r_sel_len), .size(r_sel_size), .burst(r_sel_burst),
    .next_addr(r_next), .err(r_err)
  );

`ifdef AXI4_SLV_WLAST_CHK_EN
  assign wlast_err = s.WLAST != (w_beat_q == w_len_q);
`else
  logic unused_wlast;
  assign unused_wlast = s.WLAST;
  assign wlast_err    = 1'b0;
`endif

  assign w_err_any = w_err_q | w_beat_err | wlast_err;

  // Write engine: AW capture, beat acceptance, single B response.
  always_comb begin
    w_state_d = w_state_q;  w_id_d = w_id_q;      w_addr_d = w_addr_q;
    w_len_d   = w_len_q;    w_size_d = w_size_q;  w_burst_d = w_burst_q;
    w_beat_d  = w_beat_q;   w_err_d = w_err_q;    awready_d = awready_q;
    wready_d  = wready_q;   bvalid_d = bvalid_q;  bid_d = bid_q;
    bresp_d   = bresp_q;    mem_we = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (s.AWVALID && awready_q) begin
          w_id_d = s.AWID;     w_addr_d = s.AWADDR;   w_len_d = s.AWLEN;
          w_size_d = s.AWSIZE; w_burst_d = s.AWBURST; w_beat_d = '0;
          w_err_d = 1'b0;      awready_d = 1'b0;      wready_d = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s.WVALID && wready_q) begin
          mem_we   = !w_beat_err;
          w_addr_d = w_next;
          w_beat_d = w_beat_q + 8'd1;
          w_err_d  = w_err_any;
          if (w_beat_q == w_len_q) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = w_id_q;
            bresp_d   = w_err_any ? SLVERR : OKAY;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && s.BREADY) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Beat source is the AR channel while idle, else the stored next address.
  always_comb begin
    r_sel_addr   = (r_state_q == R_IDLE) ? s.ARADDR  : r_addr_q;
    r_sel_len    = (r_state_q == R_IDLE) ? s.ARLEN   : r_len_q;
    r_sel_size   = (r_state_q == R_IDLE) ? s.ARSIZE  : r_size_q;
    r_sel_burst  = (r_state_q == R_IDLE) ? s.ARBURST : r_burst_q;
    rd_beat_data = r_err ? '0 : mem[r_sel_addr[LSB +: IDX_W]];
  end

  // Read engine: registered beats, next beat loaded on each R handshake.
  always_comb begin
    r_state_d = r_state_q;  r_id_d = r_id_q;      r_addr_d = r_addr_q;
    r_len_d   = r_len_q;    r_size_d = r_size_q;  r_burst_d = r_burst_q;
    r_beat_d  = r_beat_q;   arready_d = arready_q; rvalid_d = rvalid_q;
    rid_d     = rid_q;      rdata_d = rdata_q;    rresp_d = rresp_q;
    rlast_d   = rlast_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (s.ARVALID && arready_q) begin
          r_id_d = s.ARID;     r_len_d = s.ARLEN;     r_size_d = s.ARSIZE;
          r_burst_d = s.ARBURST; r_addr_d = r_next;   r_beat_d = '0;
          rid_d = s.ARID;      rdata_d = rd_beat_data;
          rresp_d = r_err ? SLVERR : OKAY;
          rlast_d = (s.ARLEN == 8'd0);
          rvalid_d = 1'b1;     arready_d = 1'b0;      r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && s.RREADY) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            r_addr_d = r_next;
            r_beat_d = r_beat_q + 9'd1;
            rdata_d  = rd_beat_data;
            rresp_d  = r_err ? SLVERR : OKAY;
            rlast_d  = ((r_beat_q + 9'd1) == {1'b0, r_len_q});
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // State and output registers for both engines.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE; w_id_q <= '0; w_addr_q <= '0; w_len_q <= '0;
      w_size_q <= '0; w_burst_q <= '0; w_beat_q <= '0; w_err_q <= 1'b0;
      awready_q <= 1'b0; wready_q <= 1'b0; bvalid_q <= 1'b0;
      bid_q <= '0; bresp_q <= '0;
      r_state_q <= R_IDLE; r_id_q <= '0; r_addr_q <= '0; r_len_q <= '0;
      r_size_q <= '0; r_burst_q <= '0; r_beat_q <= '0;
      arready_q <= 1'b0; rvalid_q <= 1'b0; rid_q <= '0; rdata_q <= '0;
      rresp_q <= '0; rlast_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d; w_id_q <= w_id_d; w_addr_q <= w_addr_d;
      w_len_q <= w_len_d; w_size_q <= w_size_d; w_burst_q <= w_burst_d;
      w_beat_q <= w_beat_d; w_err_q <= w_err_d; awready_q <= awready_d;
      wready_q <= wready_d; bvalid_q <= bvalid_d; bid_q <= bid_d;
      bresp_q <= bresp_d;
      r_state_q <= r_state_d; r_id_q <= r_id_d; r_addr_q <= r_addr_d;
      r_len_q <= r_len_d; r_size_q <= r_size_d; r_burst_q <= r_burst_d;
      r_beat_q <= r_beat_d; arready_q <= arready_d; rvalid_q <= rvalid_d;
      rid_q <= rid_d; rdata_q <= rdata_d; rresp_q <= rresp_d;
      rlast_q <= rlast_d;
    end
  end

  // Byte-strobed memory write; contents survive reset.
  always_ff @(posedge ACLK) begin
    if (mem_we && !ARESET) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (s.WSTRB[b]) mem[w_addr_q[LSB +: IDX_W]][8*b +: 8] <= s.WDATA[8*b +: 8];
      end
    end
  end

  assign s.AWREADY = awready_q;
  assign s.WREADY  = wready_q;
  assign s.BVALID  = bvalid_q;
  assign s.BID     = bid_q;
  assign s.BRESP   = bresp_q;
  assign s.ARREADY = arready_q;
  assign s.RVALID  = rvalid_q;
  assign s.RID     = rid_q;
  assign s.RDATA   = rdata_q;
  assign s.RRESP   = rresp_q;
  assign s.RLAST   = rlast_q;
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Scoreboard bench for axi4_slave_mem: stimulus pushes expected B/R items,
// a negedge monitor pops and compares them on every handshake.
module tb_axi4_slave_mem;
  import axi4_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_slave_mem_if #(.DATA_W(32), .ADDR_W(32), .ID_W(4)) axi ();

  axi4_slave_mem #(.DATA_W(32), .ADDR_W(32), .ID_W(4), .MEM_WORDS(1024)) dut (
    .ACLK(clk), .ARESET(rst), .s(axi)
  );

  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;

  r_exp_t      exp_r[$];
  b_exp_t      exp_b[$];
  logic [31:0] wbuf[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare each B/R handshake against the queue head.
  always @(negedge clk) begin
    b_exp_t be;
    r_exp_t re;
    if (!rst && axi.BVALID && axi.BREADY) begin
      if (exp_b.size() == 0) check("b_unexpected", 64'(axi.BVALID), 0);
      else begin
        be = exp_b.pop_front();
        check("bid", 64'(axi.BID), 64'(be.id));
        check("bresp", 64'(axi.BRESP), 64'(be.resp));
      end
    end
    if (!rst && axi.RVALID && axi.RREADY) begin
      if (exp_r.size() == 0) check("r_unexpected", 64'(axi.RVALID), 0);
      else begin
        re = exp_r.pop_front();
        check("rid", 64'(axi.RID), 64'(re.id));
        check("rdata", 64'(axi.RDATA), 64'(re.data));
        check("rresp", 64'(axi.RRESP), 64'(re.resp));
        check("rlast", 64'(axi.RLAST), 64'(re.last));
      end
    end
  end

  task automatic wait_rdy(input int ch, input string nm);
    logic r;
    int t = 0;
    do begin
      @(negedge clk);
      case (ch)
        0:       r = axi.AWREADY;
        1:       r = axi.WREADY;
        default: r = axi.ARREADY;
      endcase
      tick();
      t++;
    end while (!r && t < 100);
    if (!r) check({nm, "_ready_timeout"}, 64'(r), 1);
  endtask

  task automatic aw_hs(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    axi.AWID = id; axi.AWADDR = addr; axi.AWLEN = len; axi.AWSIZE = size; axi.AWBURST = burst;
    axi.AWVALID = 1'b1;
    wait_rdy(0, "aw");
    axi.AWVALID = 1'b0;
  endtask

  task automatic w_hs(input logic [31:0] d, input logic [3:0] strb, input logic last);
    axi.WDATA = d; axi.WSTRB = strb; axi.WLAST = last; axi.WVALID = 1'b1;
    wait_rdy(1, "w");
    axi.WVALID = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                          input logic [1:0] resp);
    b_exp_t e;
    e.id = id; e.resp = resp;
    exp_b.push_back(e);
    aw_hs(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) w_hs(wbuf[i], strb, i == int'(len));
  endtask

  task automatic exp_rd(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp,
                        input logic last);
    r_exp_t e;
    e.id = id; e.data = d; e.resp = resp; e.last = last;
    exp_r.push_back(e);
  endtask

  task automatic ar_hs(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    axi.ARID = id; axi.ARADDR = addr; axi.ARLEN = len; axi.ARSIZE = size; axi.ARBURST = burst;
    axi.ARVALID = 1'b1;
    wait_rdy(2, "ar");
    axi.ARVALID = 1'b0;
    check("r_first_valid", 64'(axi.RVALID), 1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_r.size() != 0 || exp_b.size() != 0) && t < 300) begin
      tick();
      t++;
    end
    check("drain_pending", 64'(exp_r.size() + exp_b.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axi.AWVALID = 0; axi.AWID = 0; axi.AWADDR = 0; axi.AWLEN = 0; axi.AWSIZE = 0; axi.AWBURST = 0;
    axi.WVALID = 0; axi.WDATA = 0; axi.WSTRB = 0; axi.WLAST = 0; axi.BREADY = 1;
    axi.ARVALID = 0; axi.ARID = 0; axi.ARADDR = 0; axi.ARLEN = 0; axi.ARSIZE = 0; axi.ARBURST = 0;
    axi.RREADY = 1;
    repeat (3) tick();
    check("rst_awready", 64'(axi.AWREADY), 0);
    check("rst_wready", 64'(axi.WREADY), 0);
    check("rst_bvalid", 64'(axi.BVALID), 0);
    check("rst_arready", 64'(axi.ARREADY), 0);
    check("rst_rvalid", 64'(axi.RVALID), 0);
    check("rst_bid_bresp", 64'({axi.BID, axi.BRESP}), 0);
    check("rst_r_payload", 64'({axi.RID, axi.RDATA, axi.RRESP, axi.RLAST}), 0);
    rst = 1'b0;
    tick();

    // INCR write then readback
    wbuf = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_write(4'd3, 32'h100, 8'd3, 3'd2, INCR, 4'hF, OKAY);
    wait_drain();
    for (int i = 0; i < 4; i++) exp_rd(4'd5, 32'hA0 + 32'(i), OKAY, i == 3);
    ar_hs(4'd5, 32'h100, 8'd3, 3'd2, INCR);
    wait_drain();

    // WRAP read: 0x38, 0x3C, 0x30, 0x34
    wbuf = '{32'hC0DE0030, 32'hC0DE0034, 32'hC0DE0038, 32'hC0DE003C};
    do_write(4'd1, 32'h30, 8'd3, 3'd2, INCR, 4'hF, OKAY);
    wait_drain();
    exp_rd(4'd2, 32'hC0DE0038, OKAY, 1'b0);
    exp_rd(4'd2, 32'hC0DE003C, OKAY, 1'b0);
    exp_rd(4'd2, 32'hC0DE0030, OKAY, 1'b0);
    exp_rd(4'd2, 32'hC0DE0034, OKAY, 1'b1);
    ar_hs(4'd2, 32'h38, 8'd3, 3'd2, WRAP);
    wait_drain();

    // Partial strobes: bytes 0 and 2 replaced
    wbuf = '{32'h11223344};
    do_write(4'd4, 32'h200, 8'd0, 3'd2, INCR, 4'hF, OKAY);
    wbuf = '{32'hDEADBEEF};
    do_write(4'd4, 32'h200, 8'd0, 3'd2, INCR, 4'b0101, OKAY);
    wait_drain();
    exp_rd(4'd6, 32'h11AD33EF, OKAY, 1'b1);
    ar_hs(4'd6, 32'h200, 8'd0, 3'd2, INCR);
    wait_drain();

    // Top of memory: second beat out of range on both paths
    wbuf = '{32'h5A5A0FFC, 32'h00000BAD};
    do_write(4'd9, 32'hFFC, 8'd1, 3'd2, INCR, 4'hF, SLVERR);
    wait_drain();
    exp_rd(4'd9, 32'h5A5A0FFC, OKAY, 1'b0);
    exp_rd(4'd9, 32'h0, SLVERR, 1'b1);
    ar_hs(4'd9, 32'hFFC, 8'd1, 3'd2, INCR);
    wait_drain();

    // FIXED burst: last beat wins at the same word
    wbuf = '{32'h1, 32'h2, 32'h3};
    do_write(4'd10, 32'h500, 8'd2, 3'd2, FIXED, 4'hF, OKAY);
    wait_drain();
    exp_rd(4'd10, 32'h3, OKAY, 1'b1);
    ar_hs(4'd10, 32'h500, 8'd0, 3'd2, INCR);
    wait_drain();

    // Read back-pressure mid-burst with a concurrent write burst
    wbuf = '{32'hBEEF0400, 32'hBEEF0404, 32'hBEEF0408, 32'hBEEF040C};
    fork
      begin
        int t = 0;
        for (int i = 0; i < 4; i++) exp_rd(4'd5, 32'hA0 + 32'(i), OKAY, i == 3);
        ar_hs(4'd5, 32'h100, 8'd3, 3'd2, INCR);
        while (exp_r.size() != 3 && t < 50) begin tick(); t++; end
        axi.RREADY = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("stall_rvalid", 64'(axi.RVALID), 1);
          check("stall_rdata", 64'(axi.RDATA), 64'(exp_r[0].data));
          check("stall_rlast", 64'(axi.RLAST), 64'(exp_r[0].last));
          tick();
        end
        axi.RREADY = 1'b1;
      end
      do_write(4'd8, 32'h400, 8'd3, 3'd2, INCR, 4'hF, OKAY);
    join
    wait_drain();
    for (int i = 0; i < 4; i++) exp_rd(4'd2, wbuf[i], OKAY, i == 3);
    ar_hs(4'd2, 32'h400, 8'd3, 3'd2, INCR);
    wait_drain();

    // Reset during beat 2 of 4: no B, written beats kept
    aw_hs(4'd7, 32'h300, 8'd3, 3'd2, INCR);
    w_hs(32'h33000300, 4'hF, 1'b0);
    w_hs(32'h33000304, 4'hF, 1'b0);
    rst = 1'b1;
    tick();
    check("inrst_awready", 64'(axi.AWREADY), 0);
    check("inrst_bvalid", 64'(axi.BVALID), 0);
    check("inrst_wready", 64'(axi.WREADY), 0);
    tick();
    rst = 1'b0;
    tick();
    check("postrst_awready", 64'(axi.AWREADY), 1);
    repeat (5) tick();
    check("postrst_bvalid", 64'(axi.BVALID), 0);
    exp_rd(4'd7, 32'h33000300, OKAY, 1'b0);
    exp_rd(4'd7, 32'h33000304, OKAY, 1'b1);
    ar_hs(4'd7, 32'h300, 8'd1, 3'd2, INCR);
    wait_drain();

    // Error classes: reserved burst, oversize, illegal wrap length
    wbuf = '{32'h77};
    do_write(4'd11, 32'h600, 8'd0, 3'd2, 2'b11, 4'hF, SLVERR);
    wait_drain();
    exp_rd(4'd12, 32'h0, SLVERR, 1'b1);
    ar_hs(4'd12, 32'h0, 8'd0, 3'd3, INCR);
    wait_drain();
    for (int i = 0; i < 3; i++) exp_rd(4'd13, 32'h0, SLVERR, i == 2);
    ar_hs(4'd13, 32'h30, 8'd2, 3'd2, WRAP);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
